// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and the per-cycle action decode for the inter-stage pipeline register.
// Stall-vector indices name the upstream stage a register sits behind.
package pipe_stage_reg_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic STOP        = 1'b1;
    localparam logic NO_STOP     = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int STALL_BUS_W = 6;
    localparam int STAGE_IF    = 0;
    localparam int STAGE_ID    = 1;
    localparam int STAGE_EX    = 2;
    localparam int STAGE_MEM   = 3;
    localparam int STAGE_WB    = 4;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // Flush beats every stall combination; a stalled upstream with a moving downstream leaves a bubble.
    function automatic stage_act_e decode_act(input logic flush, input logic up_stall,
                                              input logic dn_stall);
        stage_act_e act;
        if (flush)
            act = ACT_FLUSH;
        else if (up_stall == NO_STOP)
            act = ACT_ADVANCE;
        else if (dn_stall == NO_STOP)
            act = ACT_BUBBLE;
        else
            act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of stall/flush control, payload in/out and performance counters for one pipeline register.
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 32,
    parameter int FB_W    = 1,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 16
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [FB_W-1:0]    in_fb;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [FB_W-1:0]    out_fb;
    logic               cnt_clr;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   kill_cnt;

    modport master (
        output stall, flush, in_valid, in_data, in_fb, cnt_clr,
        input  out_valid, out_data, out_fb, hold_cnt, bubble_cnt, kill_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_data, in_fb, cnt_clr,
        output out_valid, out_data, out_fb, hold_cnt, bubble_cnt, kill_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous reset and clear; clear overrides increment.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register driven by the shared stall vector and flush line,
// with a one-cycle feedback sideband and hold/bubble/kill performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                FB_W      = 1,
    parameter int                STALL_W   = STALL_BUS_W,
    parameter int                STAGE     = STAGE_EX,
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      bus
);
    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
        end
    endgenerate

    stage_act_e act;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [FB_W-1:0]   fb_q,    fb_d;
    logic              hold_inc, bubble_inc, kill_inc;

    assign act = decode_act(bus.flush, bus.stall[STAGE], bus.stall[STAGE+1]);

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        fb_d       = fb_q;
        hold_inc   = 1'b0;
        bubble_inc = 1'b0;
        kill_inc   = 1'b0;
        unique case (act)
            ACT_FLUSH: begin
                valid_d  = 1'b0;
                data_d   = NOP_VALUE;
                fb_d     = '0;
                kill_inc = valid_q;
            end
            ACT_BUBBLE: begin
                valid_d    = 1'b0;
                data_d     = NOP_VALUE;
                fb_d       = '0;
                bubble_inc = 1'b1;
            end
            ACT_ADVANCE: begin
                valid_d = bus.in_valid;
                data_d  = bus.in_valid ? bus.in_data : NOP_VALUE;
                fb_d    = bus.in_fb;
            end
            ACT_HOLD: begin
                hold_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
            fb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            fb_q    <= fb_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_fb    = fb_q;

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(hold_inc),   .cnt(bus.hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(bubble_inc), .cnt(bus.bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_kill_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(kill_inc),   .cnt(bus.kill_cnt)
    );
endmodule
